muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle MULTU/DIVU sequencer that time-shares the single EX-stage ALU with the pipeline.
- Sits beside the EX stage and owns the ALU operand/opcode mux.
  - Idle: EX-stage requests pass straight through.
  - Busy: drives ALU add (4'h1) / sub (4'h2) once per cycle for a 32-step shift-add multiply or restoring divide.
  - Busy: stalls the pipeline until HI/LO are written.

Parameters:
- WIDTH, 32, operand/HI/LO width; must equal ALU width.
- CNT_W, 5, iteration counter width, log2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EX stage issues a mult/div this cycle
- md_op  in  1  0 = MULTU, 1 = DIVU; sampled with start
- rs_val  in  32  multiplicand / dividend
- rt_val  in  32  multiplier / divisor
- flush  in  1  synchronous abort of the in-flight operation
- ex_alu_op  in  4  EX-stage ALU opcode request
- ex_op_1  in  32  EX-stage operand 1
- ex_op_2  in  32  EX-stage operand 2
- alu_result  in  32  result from the shared ALU
- alu_op  out  4  opcode to the ALU
- alu_op_1  out  32  operand 1 to the ALU
- alu_op_2  out  32  operand 2 to the ALU
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  sequencer owns the ALU; also the pipeline stall request
- done  out  1  one-cycle pulse: HI/LO just updated
- dz  out  1  sticky: last DIVU had divisor 0

Behaviour:
- Reset (rst_n low, async): state IDLE, count 0, hi/lo/operand regs 0, busy 0, done 0, dz 0.
- States: IDLE, RUN, FIN.
  - IDLE: start=1 -> RUN. Latch md_op; latch opnd = (md_op ? rt_val : rs_val); hi <= 0; lo <= (md_op ? rs_val : rt_val); count <= 0; dz <= md_op & (rt_val==0).
  - RUN: one iteration per cycle. count==31 -> FIN, else count+1.
  - FIN: done=1 for exactly one cycle -> IDLE.
- busy = (state==RUN), a registered state decode. done = (state==FIN).
- Latency: start at cycle T -> busy high T+1..T+32 (32 cycles) -> done high T+33, with final hi/lo visible at T+33.
- ALU mux:
  - When not busy: alu_op/op_1/op_2 = ex_* (combinational pass-through, zero latency). This includes the start cycle and FIN.
  - When busy: sequencer drives the ALU. ex_* are ignored.
- MULTU iteration:
  - Drives alu_op=4'h1, alu_op_1=hi, alu_op_2 = lo[0] ? opnd : 0; s = alu_result.
  - Carry from MSBs: c = (a31&b31) | ((a31|b31)&~s31), where a = op_1, b = op_2.
  - Update: {hi,lo} <= {c, s, lo[31:1]}.
- DIVU iteration:
  - sh = {hi[30:0], lo[31]}, m = hi[31].
  - Drives alu_op=4'h2, alu_op_1=sh, alu_op_2=opnd; d = alu_result.
  - Borrow from MSBs: bw = (~a31&b31) | ((~a31|b31)&d31).
  - q = m | ~bw. hi <= q ? d : sh. lo <= {lo[30:0], q}.
  - Final: lo = quotient, hi = remainder.
- Divisor 0: no special path. The algorithm yields lo=32'hFFFFFFFF, hi=dividend, and dz=1.
- ALU z output unused. ALU signedness irrelevant: only add/sub bit patterns are used.
- start while busy or in FIN: ignored; no queueing.
- flush:
  - Synchronous, highest priority over start and iteration.
  - Any state -> IDLE, done not asserted, hi/lo keep their current partial value.
  - The software model treats hi/lo as undefined after flush.
- rst_n low mid-operation: immediate return to reset values, busy drops asynchronously.

Decomposition:
- Shared package holds:
  - ALU opcode constants ALU_ADD=4'h1, ALU_SUB=4'h2 (and the rest of the ALU opcode table).
  - MD_MULTU=1'b0, MD_DIVU=1'b1.
  - State encoding IDLE/RUN/FIN.
- One natural sub-module: md_flags. Combinational; from a31, b31, s31 it produces carry (add) and borrow (sub). Unit-testable in isolation.

Test Plan:
- MULTU rs=32'h0000_0007, rt=32'h0000_0006 -> busy 32 cycles, done at T+33, hi=0, lo=32'h2A; ex_* pass-through before and after.
- MULTU rs=rt=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; exercises carry on every step.
- DIVU rs=32'd100, rt=32'd7 -> lo=14, hi=2, dz=0. DIVU rs=32'h8000_0001, rt=2 -> lo=32'h4000_0000, hi=1; exercises MSB shift-out.
- DIVU rs=32'h1234_5678, rt=0 -> lo=32'hFFFF_FFFF, hi=32'h1234_5678, dz=1.
- During busy: drive ex_alu_op=4'h5 and pulse start -> alu_op stays 4'h1/4'h2, second start ignored, results unaffected.
- Flush at iteration 10 -> IDLE next cycle, no done pulse. Deassert rst_n mid-DIVU -> busy/done/hi/lo/dz 0 immediately; a following MULTU 3×4 gives lo=12.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the MULTU/DIVU sequencer: ALU opcodes,
// mult/div selector encoding and sequencer state encoding.
package muldiv_seq_pkg;

  localparam logic [3:0] ALU_NOP  = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_NOR  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_SLTU = 4'h8;
  localparam logic [3:0] ALU_SLL  = 4'h9;
  localparam logic [3:0] ALU_SRL  = 4'hA;
  localparam logic [3:0] ALU_SRA  = 4'hB;
  localparam logic [3:0] ALU_LUI  = 4'hC;

  localparam logic MD_MULTU = 1'b0;
  localparam logic MD_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_flags.sv
// Recovers the carry-out of an add and the borrow-out of a subtract from
// the operand and result MSBs, since the shared ALU exports neither.
module md_flags (
  input  logic a_msb,
  input  logic b_msb,
  input  logic r_msb,
  output logic carry,
  output logic borrow
);

  assign carry  = (a_msb & b_msb) | ((a_msb | b_msb) & ~r_msb);
  assign borrow = (~a_msb & b_msb) | ((~a_msb | b_msb) & r_msb);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer sharing the EX-stage ALU: passes EX
// requests through when idle, runs a 32-step shift-add / restoring divide when busy.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic [3:0]       ex_alu_op,
  input  logic [WIDTH-1:0] ex_op_1,
  input  logic [WIDTH-1:0] ex_op_2,
  input  logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_op_1,
  output logic [WIDTH-1:0] alu_op_2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  md_state_e        state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             op_reg, op_next;
  logic [WIDTH-1:0] opnd_reg, opnd_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             dz_reg, dz_next;

  logic [WIDTH-1:0] div_sh;
  logic             div_m;
  logic             div_q;
  logic             carry;
  logic             borrow;

  // Divide step works on the 33-bit partial remainder {hi, lo[MSB]};
  // the bit shifted out of hi forces a quotient 1 regardless of the borrow.
  assign div_sh = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
  assign div_m  = hi_reg[WIDTH-1];
  assign div_q  = div_m | ~borrow;

  md_flags u_flags (
    .a_msb  (alu_op_1[WIDTH-1]),
    .b_msb  (alu_op_2[WIDTH-1]),
    .r_msb  (alu_result[WIDTH-1]),
    .carry  (carry),
    .borrow (borrow)
  );

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_FIN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign dz   = dz_reg;

  always_comb begin
    alu_op   = ex_alu_op;
    alu_op_1 = ex_op_1;
    alu_op_2 = ex_op_2;
    if (busy) begin
      if (op_reg == MD_DIVU) begin
        alu_op   = ALU_SUB;
        alu_op_1 = div_sh;
        alu_op_2 = opnd_reg;
      end else begin
        alu_op   = ALU_ADD;
        alu_op_1 = hi_reg;
        alu_op_2 = lo_reg[0] ? opnd_reg : '0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    op_next    = op_reg;
    opnd_next  = opnd_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    dz_next    = dz_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          op_next    = md_op;
          opnd_next  = md_op ? rt_val : rs_val;
          hi_next    = '0;
          lo_next    = md_op ? rs_val : rt_val;
          count_next = '0;
          dz_next    = md_op & (rt_val == '0);
        end
      end
      ST_RUN: begin
        if (op_reg == MD_DIVU) begin
          hi_next = div_q ? alu_result : div_sh;
          lo_next = {lo_reg[WIDTH-2:0], div_q};
        end else begin
          {hi_next, lo_next} = {carry, alu_result, lo_reg[WIDTH-1:1]};
        end
        if (count_reg == CNT_W'(WIDTH - 1)) begin
          state_next = ST_FIN;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort freezes all datapath state; only the FSM returns to idle.
    if (flush) begin
      state_next = ST_IDLE;
      count_next = count_reg;
      op_next    = op_reg;
      opnd_next  = opnd_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      dz_next    = dz_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      op_reg    <= MD_MULTU;
      opnd_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      op_reg    <= op_next;
      opnd_reg  <= opnd_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      dz_reg    <= dz_next;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        md_op;
  logic [31:0] rs_val, rt_val;
  logic        flush;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_op_1, ex_op_2;
  logic [31:0] alu_result;
  logic [3:0]  alu_op;
  logic [31:0] alu_op_1, alu_op_2;
  logic [31:0] hi, lo;
  logic        busy, done, dz;

  int total = 0;
  int bad   = 0;

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .md_op      (md_op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .flush      (flush),
    .ex_alu_op  (ex_alu_op),
    .ex_op_1    (ex_op_1),
    .ex_op_2    (ex_op_2),
    .alu_result (alu_result),
    .alu_op     (alu_op),
    .alu_op_1   (alu_op_1),
    .alu_op_2   (alu_op_2),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .dz         (dz)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'h1:    alu_result = alu_op_1 + alu_op_2;
      4'h2:    alu_result = alu_op_1 - alu_op_2;
      default: alu_result = alu_op_1 ^ alu_op_2;
    endcase
  end

  typedef struct {
    logic        md;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one operation; returns number of busy cycles and the cycle (after start) of done.
  task automatic run_op(input logic md, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output int done_at);
    @(posedge clk); #1;
    start = 1'b1; md_op = md; rs_val = a; rt_val = b;
    ex_alu_op = 4'h5; ex_op_1 = 32'hA5A5_0000; ex_op_2 = 32'h0000_5A5A;
    @(negedge clk);
    check("start_pass_op", {28'd0, alu_op}, 32'h5);
    check("start_pass_op1", alu_op_1, 32'hA5A5_0000);
    @(posedge clk); #1;
    start = 1'b0;
    nbusy = 0;
    done_at = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_at = cyc;
        break;
      end
      if (busy) begin
        nbusy++;
        if (cyc == 5) check("busy_alu_op", {28'd0, alu_op}, md ? 32'h2 : 32'h1);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, dat, ndone;

    vecs[0] = '{1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[3] = '{1'b1, 32'h8000_0001, 32'h0000_0002, 32'h0000_0001, 32'h4000_0000, 1'b0};
    vecs[4] = '{1'b1, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, 32'd5,         32'd10,        32'd5,         32'd0,         1'b0};

    rst_n = 1'b0; start = 1'b0; md_op = 1'b0; rs_val = '0; rt_val = '0; flush = 1'b0;
    ex_alu_op = 4'h3; ex_op_1 = 32'h1111_2222; ex_op_2 = 32'h3333_4444;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dz", {31'd0, dz}, 32'd0);
    check("rst_pass_op", {28'd0, alu_op}, 32'h3);
    check("rst_pass_op2", alu_op_2, 32'h3333_4444);
    $display("reset: busy=%0b done=%0b hi=%h lo=%h dz=%0b", busy, done, hi, lo, dz);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].md, vecs[i].rs, vecs[i].rt, nb, dat);
      check("busy_cycles", 32'(nb), 32'd32);
      check("done_cycle", 32'(dat), 32'd33);
      check("hi", hi, vecs[i].exp_hi);
      check("lo", lo, vecs[i].exp_lo);
      check("dz", {31'd0, dz}, {31'd0, vecs[i].exp_dz});
      $display("vec %0d: md=%0b rs=%h rt=%h -> hi=%h lo=%h dz=%0b busy=%0d done@%0d",
               i, vecs[i].md, vecs[i].rs, vecs[i].rt, hi, lo, dz, nb, dat);
      @(posedge clk); #1;
      ex_alu_op = 4'h9; ex_op_1 = 32'hCAFE_0000 + 32'(i);
      @(negedge clk);
      check("post_done_low", {31'd0, done}, 32'd0);
      check("post_pass_op", {28'd0, alu_op}, 32'h9);
      check("post_pass_op1", alu_op_1, 32'hCAFE_0000 + 32'(i));
    end

    // Second start and EX traffic during busy must be ignored.
    @(posedge clk); #1;
    start = 1'b1; md_op = 1'b0; rs_val = 32'd7; rt_val = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ex_alu_op = 4'h5; ex_op_1 = 32'hDEAD_BEEF; start = 1'b1; md_op = 1'b1; rs_val = 32'd9; rt_val = 32'd0;
    @(negedge clk);
    check("intf_busy", {31'd0, busy}, 32'd1);
    check("intf_alu_op", {28'd0, alu_op}, 32'h1);
    @(posedge clk); #1;
    start = 1'b0;
    dat = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        dat = cyc;
        break;
      end
    end
    check("intf_done_seen", {31'd0, (dat != 0)}, 32'd1);
    check("intf_lo", lo, 32'h2A);
    check("intf_hi", hi, 32'h0);
    check("intf_dz", {31'd0, dz}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("intf_no_restart", {31'd0, busy}, 32'd0);
    $display("interference: hi=%h lo=%h dz=%0b busy_after=%0b", hi, lo, dz, busy);

    // Flush during iteration 10 of a divide.
    @(posedge clk); #1;
    start = 1'b1; md_op = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; ex_alu_op = 4'h7; ex_op_2 = 32'h0BAD_F00D;
    @(negedge clk);
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    check("flush_pass_op", {28'd0, alu_op}, 32'h7);
    check("flush_pass_op2", alu_op_2, 32'h0BAD_F00D);
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("flush_no_done", 32'(ndone), 32'd0);
    $display("flush: busy=%0b done_or_busy_cycles=%0d", busy, ndone);

    // Asynchronous reset in the middle of a divide-by-zero.
    @(posedge clk); #1;
    start = 1'b1; md_op = 1'b1; rs_val = 32'h1234_5678; rt_val = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_dz", {31'd0, dz}, 32'd1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    check("mid_rst_dz", {31'd0, dz}, 32'd0);
    $display("mid-op reset: busy=%0b hi=%h lo=%h dz=%0b", busy, hi, lo, dz);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(1'b0, 32'd3, 32'd4, nb, dat);
    check("after_rst_cycles", 32'(dat), 32'd33);
    check("after_rst_lo", lo, 32'd12);
    check("after_rst_hi", hi, 32'd0);
    $display("post-reset multu 3x4: hi=%h lo=%h done@%0d", hi, lo, dat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
